// File: rtl/game_pkg.sv
// Shared widths, 7-segment encodings and FSM state type for the game time display.
package game_pkg;

    localparam int CNT_W = 10;
    localparam int BCD_W = 16;

    // Active-low segments, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = SEG_0;
            4'd1:    seg7 = SEG_1;
            4'd2:    seg7 = SEG_2;
            4'd3:    seg7 = SEG_3;
            4'd4:    seg7 = SEG_4;
            4'd5:    seg7 = SEG_5;
            4'd6:    seg7 = SEG_6;
            4'd7:    seg7 = SEG_7;
            4'd8:    seg7 = SEG_8;
            4'd9:    seg7 = SEG_9;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one iteration per clock.
module bin2bcd_seq
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int SR_W = BCD_W + CNT_W;

    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] adj;
    logic [3:0]      iter;
    logic            running;

    always_comb begin
        adj = sr;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (sr[CNT_W + 4*i +: 4] >= 4'd5) begin
                adj[CNT_W + 4*i +: 4] = sr[CNT_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            iter    <= '0;
            running <= 1'b0;
        end else if (start) begin
            sr      <= {{BCD_W{1'b0}}, value};
            iter    <= '0;
            running <= 1'b1;
        end else if (running) begin
            sr   <= {adj[SR_W-2:0], 1'b0};
            iter <= iter + 4'd1;
            if (iter == 4'(CNT_W - 1)) begin
                running <= 1'b0;
            end
        end
    end

    // done is high during the last iteration so the caller commits right after it
    assign done = running && (iter == 4'(CNT_W - 1));
    assign busy = running;
    assign bcd  = sr[SR_W-1:CNT_W];

endmodule

// File: rtl/game_time_display.sv
// Shows the tenths count (or a captured lap) as "ddd.d" on four HEX digits.
// Optional best-lap tracking is enabled with the GAME_BEST_TIME_EN macro.
module game_time_display
    import game_pkg::*;
(
    input  logic             CLOCK10M,
    input  logic             KEY0,
    input  logic [CNT_W-1:0] count_in,
    input  logic             lap_key,
    input  logic             SWITCH0,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic             dp1,
    output logic             busy,
    output logic             upd,
    output logic [CNT_W-1:0] lap_out,
    output logic [CNT_W-1:0] best_out,
    output logic             new_best
);

    state_t           state;
    logic [CNT_W-1:0] src;
    logic [CNT_W-1:0] last_conv;
    logic             start;
    logic             done;
    logic             conv_busy;
    logic [BCD_W-1:0] bcd;
    logic             lap_prev;
    logic             lap_edge;

    assign src      = SWITCH0 ? lap_out : count_in;
    assign start    = (state == IDLE) && (src != last_conv);
    assign lap_edge = lap_key && !lap_prev;
    assign dp1      = 1'b0;

    bin2bcd_seq u_conv (
        .clk   (CLOCK10M),
        .rst   (KEY0),
        .start (start),
        .value (src),
        .busy  (conv_busy),
        .done  (done),
        .bcd   (bcd)
    );

    always_ff @(posedge CLOCK10M) begin
        if (KEY0) begin
            state     <= IDLE;
            last_conv <= '0;
            busy      <= 1'b0;
            upd       <= 1'b0;
            hex0      <= SEG_0;
            hex1      <= SEG_0;
            hex2      <= SEG_0;
            hex3      <= SEG_0;
        end else begin
            upd <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        last_conv <= src;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (done) begin
                        state <= COMMIT;
                    end else if (!conv_busy) begin
                        // converter lost its run; recover rather than hang busy
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                COMMIT: begin
                    hex0  <= seg7(bcd[3:0]);
                    hex1  <= seg7(bcd[7:4]);
                    hex2  <= seg7(bcd[11:8]);
                    hex3  <= seg7(bcd[15:12]);
                    upd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK10M) begin
        if (KEY0) begin
            lap_prev <= 1'b0;
            lap_out  <= '0;
        end else begin
            lap_prev <= lap_key;
            if (lap_edge) begin
                lap_out <= count_in;
            end
        end
    end

`ifdef GAME_BEST_TIME_EN
    logic [CNT_W-1:0] best;
    logic             best_pulse;

    always_ff @(posedge CLOCK10M) begin
        if (KEY0) begin
            best       <= '0;
            best_pulse <= 1'b0;
        end else begin
            best_pulse <= 1'b0;
            if (lap_edge && (count_in != '0) && ((best == '0) || (count_in < best))) begin
                best       <= count_in;
                best_pulse <= 1'b1;
            end
        end
    end

    assign best_out = best;
    assign new_best = best_pulse;
`else
    assign best_out = '0;
    assign new_best = 1'b0;
`endif

endmodule

// File: tb/tb_game_time_display.sv
// Scoreboard bench for game_time_display: expected displays queued on stimulus, checked on upd.
module tb_game_time_display;

    logic       CLOCK10M = 1'b0;
    logic       KEY0 = 1'b1;
    logic [9:0] count_in = '0;
    logic       lap_key = 1'b0;
    logic       SWITCH0 = 1'b0;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       dp1, busy, upd, new_best;
    logic [9:0] lap_out, best_out;

    typedef struct {
        logic [27:0] disp;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    game_time_display dut (
        .CLOCK10M (CLOCK10M),
        .KEY0     (KEY0),
        .count_in (count_in),
        .lap_key  (lap_key),
        .SWITCH0  (SWITCH0),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .dp1      (dp1),
        .busy     (busy),
        .upd      (upd),
        .lap_out  (lap_out),
        .best_out (best_out),
        .new_best (new_best)
    );

    always #50 CLOCK10M = ~CLOCK10M;
    always @(posedge CLOCK10M) cyc <= cyc + 1;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'h40;
            1: seg = 7'h79;
            2: seg = 7'h24;
            3: seg = 7'h30;
            4: seg = 7'h19;
            5: seg = 7'h12;
            6: seg = 7'h02;
            7: seg = 7'h78;
            8: seg = 7'h00;
            9: seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] to_disp(input int v);
        to_disp = {seg((v / 1000) % 10), seg((v / 100) % 10), seg((v / 10) % 10), seg(v % 10)};
    endfunction

    // Scoreboard side: every upd pulse must match the oldest queued display and its due cycle.
    always @(negedge CLOCK10M) begin
        if (upd === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_upd: cycle %0d display %h, no update was expected",
                         cyc, {hex3, hex2, hex1, hex0});
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({hex3, hex2, hex1, hex0} !== e.disp || cyc !== e.due) begin
                    $display("FAIL commit: got display %h at cycle %0d, want %h at cycle %0d",
                             {hex3, hex2, hex1, hex0}, cyc, e.disp, e.due);
                end else begin
                    passed++;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK10M);
        #1;
    endtask

    task automatic push(input int v, input int delay);
        exp_t e;
        e.disp = to_disp(v);
        e.due  = cyc + delay;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d updates still pending, want 0", sb.size());
            sb.delete();
        end
        tick(2);
    endtask

    task automatic test_reset();
        KEY0 = 1'b1;
        tick(2);
        checks += 7;
        if ({hex3, hex2, hex1, hex0} !== {4{7'b1000000}})
            $display("FAIL reset_hex: got %h want %h", {hex3, hex2, hex1, hex0}, {4{7'b1000000}});
        else passed++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        if (upd !== 1'b0) $display("FAIL reset_upd: got %b want 0", upd); else passed++;
        if (lap_out !== 10'd0) $display("FAIL reset_lap: got %0d want 0", lap_out); else passed++;
        if (best_out !== 10'd0) $display("FAIL reset_best: got %0d want 0", best_out); else passed++;
        if (new_best !== 1'b0) $display("FAIL reset_nb: got %b want 0", new_best); else passed++;
        if (dp1 !== 1'b0) $display("FAIL reset_dp1: got %b want 0", dp1); else passed++;
        KEY0 = 1'b0;
        tick(3);
    endtask

    task automatic test_max_count();
        count_in = 10'd1023;
        push(1023, 12);
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_before: got %b want 0", busy); else passed++;
        tick(1);
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", busy); else passed++;
        wait_drain();
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_fall: got %b want 0", busy); else passed++;
    endtask

    task automatic test_wrap();
        count_in = 10'd0;
        push(0, 12);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        count_in = 10'd5;
        push(5, 12);
        push(6, 24);
        tick(4);
        count_in = 10'd6;
        wait_drain();
    endtask

    task automatic test_lap_display();
        count_in = 10'd37;
        push(37, 12);
        lap_key = 1'b1;
        tick(1);
        checks++;
        if (lap_out !== 10'd37) $display("FAIL lap_capture: got %0d want 37", lap_out); else passed++;
        tick(12);
        count_in = 10'd38;
        push(38, 12);
        tick(7);
        checks++;
        if (lap_out !== 10'd37) $display("FAIL lap_held: got %0d want 37", lap_out); else passed++;
        lap_key = 1'b0;
        wait_drain();
        SWITCH0 = 1'b1;
        push(37, 12);
        wait_drain();
        count_in = 10'd200;
        tick(20);
        checks++;
        if ({hex3, hex2, hex1, hex0} !== to_disp(37) || busy !== 1'b0)
            $display("FAIL lap_hold_display: got %h busy %b want %h busy 0",
                     {hex3, hex2, hex1, hex0}, busy, to_disp(37));
        else passed++;
    endtask

    task automatic test_best_time();
        int vals[4] = '{50, 0, 42, 60};
`ifdef GAME_BEST_TIME_EN
        int exp_best[4] = '{50, 50, 42, 42};
        int exp_nb[4] = '{1, 0, 1, 0};
`else
        int exp_best[4] = '{0, 0, 0, 0};
        int exp_nb[4] = '{0, 0, 0, 0};
`endif
        SWITCH0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            count_in = 10'(vals[i]);
            push(vals[i], 12);
            lap_key = 1'b1;
            tick(1);
            checks += 4;
            if (lap_out !== 10'(vals[i]))
                $display("FAIL best_lap%0d: got %0d want %0d", i, lap_out, vals[i]);
            else passed++;
            if (best_out !== 10'(exp_best[i]))
                $display("FAIL best_val%0d: got %0d want %0d", i, best_out, exp_best[i]);
            else passed++;
            if (new_best !== 1'(exp_nb[i]))
                $display("FAIL best_pulse%0d: got %b want %0d", i, new_best, exp_nb[i]);
            else passed++;
            tick(1);
            if (new_best !== 1'b0)
                $display("FAIL best_pulse_end%0d: got %b want 0", i, new_best);
            else passed++;
            lap_key = 1'b0;
            wait_drain();
        end
    endtask

    task automatic test_reset_abort();
        count_in = 10'd77;
        tick(6);
        KEY0 = 1'b1;
        tick(1);
        checks += 3;
        if ({hex3, hex2, hex1, hex0} !== {4{7'b1000000}})
            $display("FAIL abort_hex: got %h want %h", {hex3, hex2, hex1, hex0}, {4{7'b1000000}});
        else passed++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
        if (lap_out !== 10'd0) $display("FAIL abort_lap: got %0d want 0", lap_out); else passed++;
        KEY0 = 1'b0;
        push(77, 12);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_max_count();
        test_wrap();
        test_back_to_back();
        test_lap_display();
        test_best_time();
        test_reset_abort();
        tick(5);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
